// File: rtl/frankie_mmio_pkg.sv
// Shared register offsets, STATUS layout and FSM state type for the Frankie MMIO responder.
package frankie_mmio_pkg;

  localparam logic [1:0] OFF_DATA    = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_CYCLE   = 2'd2;
  localparam logic [1:0] OFF_SCRATCH = 2'd3;

  localparam int STATUS_FULL_BIT  = 15;
  localparam int STATUS_EMPTY_BIT = 14;
  localparam int STATUS_COUNT_W   = 7;
  localparam int STATUS_FLUSH_BIT = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    STALL = 2'd2
  } mmio_state_e;

  function automatic logic [15:0] status_word(input logic full, input logic empty,
                                              input logic [STATUS_COUNT_W-1:0] count);
    logic [15:0] w;
    w = '0;
    w[STATUS_FULL_BIT]      = full;
    w[STATUS_EMPTY_BIT]     = empty;
    w[STATUS_COUNT_W-1:0]   = count;
    return w;
  endfunction

endpackage

// File: rtl/frankie_sync_fifo.sv
// Synchronous FIFO with flush and a registered head word (out_data/out_valid style).
module frankie_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next, remain;
  logic             head_valid_reg;
  logic [WIDTH-1:0] head_data_reg;
  logic             do_push, do_pop;

  assign full       = (count_reg == (AW+1)'(DEPTH));
  assign empty      = (count_reg == '0);
  assign count      = count_reg;
  assign head_valid = head_valid_reg;
  assign head_data  = head_data_reg;

  // Flush overrides both ends; a pop is only taken while the head is presented.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & head_valid_reg & ~flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    remain      = count_reg - (AW+1)'(do_pop);
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      count_next = remain + (AW+1)'(do_push);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      head_valid_reg <= (count_next != '0);
      // When only the incoming word remains it is not in mem yet, so bypass it.
      if (count_next == '0)
        head_data_reg <= '0;
      else if (remain == '0)
        head_data_reg <= push_data;
      else
        head_data_reg <= mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/frankie_mmio_responder.sv
// Frankie data-bus MMIO responder: 4-register window with an output FIFO stream.
// Optional CYCLE counter enabled by defining FRANKIE_MMIO_CYCLE_CNT_EN.
module frankie_mmio_responder
  import frankie_mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          FIFO_DEPTH = 8,
  parameter int          DATA_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              hit,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  mmio_state_e       state_reg, state_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [DATA_W-1:0] scratch_reg, scratch_next;
  logic [DATA_W-1:0] status_val, cycle_val;
  logic [1:0]        off;
  logic              access;
  logic              fifo_push, fifo_flush, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign hit    = (addr[15:2] == BASE_ADDR[15:2]);
  assign off    = addr[1:0];
  assign access = req & hit;
  assign ready  = (state_reg == RESP);
  assign rdata  = rdata_reg;

  assign status_val = DATA_W'(status_word(fifo_full, fifo_empty, STATUS_COUNT_W'(fifo_count)));

`ifdef FRANKIE_MMIO_CYCLE_CNT_EN
  logic [15:0] cycle_reg;
  logic        cycle_clr;

  always_ff @(posedge clock) begin
    if (!reset)
      cycle_reg <= '0;
    else if (cycle_clr)
      cycle_reg <= '0;
    else
      cycle_reg <= cycle_reg + 16'd1;
  end

  assign cycle_val = DATA_W'(cycle_reg);
`else
  assign cycle_val = '0;
`endif

  always_comb begin
    state_next   = state_reg;
    rdata_next   = '0;
    scratch_next = scratch_reg;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;
`ifdef FRANKIE_MMIO_CYCLE_CNT_EN
    cycle_clr    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (access) begin
          state_next = RESP;
          if (wr) begin
            case (off)
              OFF_DATA: begin
                if (fifo_full) state_next = STALL;
                else           fifo_push  = 1'b1;
              end
              OFF_STATUS:  fifo_flush = wdata[STATUS_FLUSH_BIT];
              OFF_CYCLE: begin
`ifdef FRANKIE_MMIO_CYCLE_CNT_EN
                cycle_clr = 1'b1;
`endif
              end
              OFF_SCRATCH: scratch_next = wdata;
              default: ;
            endcase
          end else begin
            // Loads see register values from before this edge's updates.
            case (off)
              OFF_STATUS:  rdata_next = status_val;
              OFF_CYCLE:   rdata_next = cycle_val;
              OFF_SCRATCH: rdata_next = scratch_reg;
              default:     rdata_next = '0;
            endcase
          end
        end
      end
      RESP: state_next = IDLE;
      STALL: begin
        // wdata is held by the requester, so the deferred push uses it directly.
        if (!fifo_full) begin
          fifo_push  = 1'b1;
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= IDLE;
      rdata_reg   <= '0;
      scratch_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rdata_reg   <= rdata_next;
      scratch_reg <= scratch_next;
    end
  end

  frankie_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (fifo_push),
    .push_data  (wdata),
    .pop        (out_ready),
    .flush      (fifo_flush),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_valid (out_valid),
    .head_data  (out_data)
  );

endmodule

// File: tb/tb_frankie_mmio_responder.sv
// Self-checking bench for frankie_mmio_responder: directed plan steps plus random bus traffic
// checked against a queue-based model of the register window and output stream.
module tb_frankie_mmio_responder;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, wr = 1'b0, out_ready = 1'b0;
  logic [15:0] addr = 16'h0, wdata = 16'h0;
  logic        hit, ready, out_valid;
  logic [15:0] rdata, out_data;

  int          total = 0, bad = 0;
  int          edge_cnt = 0, cyc_base = 0;
  logic [15:0] q[$];
  logic [15:0] popped[$];
  logic [15:0] scratch_m = 16'h0;
  bit          m_push = 0, m_flush = 0;
  logic [15:0] m_val = 16'h0;
  logic [15:0] rd;
  int          lat;

  frankie_mmio_responder #(
    .BASE_ADDR (16'hFF00),
    .FIFO_DEPTH(DEPTH),
    .DATA_W    (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .hit      (hit),
    .rdata    (rdata),
    .ready    (ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock: verify the stream head, then apply this edge's pop/push/flush to the model.
  task automatic tick();
    bit pop_now;
    pop_now = (q.size() > 0) && out_ready;
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("out_data", 32'(out_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    @(posedge clock); #1;
    if (m_flush) q.delete();
    else begin
      if (pop_now) popped.push_back(q.pop_front());
      if (m_push) q.push_back(m_val);
    end
    m_push = 0;
    m_flush = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; req = 1'b0; wr = 1'b0; out_ready = 1'b0;
    repeat (n) @(posedge clock);
    #1;
    cyc_base = edge_cnt;
    reset = 1'b1;
    q.delete();
    scratch_m = 16'h0;
    m_push = 0;
    m_flush = 0;
  endtask

  // Full bus transaction; release_stall pulses out_ready once if the store stalls.
  task automatic bus(input bit w, input logic [1:0] off, input logic [15:0] d,
                     input bit release_stall, output logic [15:0] rdv, output int latv);
    logic [15:0] exp;
    bit stalled, was_stall;
    int l;
    exp = 16'h0; stalled = 0; l = 0;
    req = 1'b1; wr = w; addr = 16'hFF00 | {14'd0, off}; wdata = d;
    if (w) begin
      case (off)
        2'd0: if (q.size() == DEPTH) stalled = 1; else begin m_push = 1; m_val = d; end
        2'd1: m_flush = d[0];
        2'd2: cyc_base = edge_cnt + 1;
        default: scratch_m = d;
      endcase
    end else begin
      case (off)
        2'd1: exp = {q.size() == DEPTH, q.size() == 0, 7'd0, 7'(q.size())};
        2'd2: begin
`ifdef FRANKIE_MMIO_CYCLE_CNT_EN
          exp = 16'(edge_cnt - cyc_base);
`else
          exp = 16'h0;
`endif
        end
        2'd3: exp = scratch_m;
        default: exp = 16'h0;
      endcase
    end
    was_stall = stalled;
    tick();
    l = 1;
    while (stalled && l < 40) begin
      check("stall_ready", 32'(ready), 32'd0);
      if (release_stall) out_ready = (l == 2);
      if (q.size() < DEPTH) begin
        m_push = 1; m_val = d; stalled = 0;
      end
      tick();
      l++;
    end
    check("ready", 32'(ready), 32'd1);
    check("rdata", 32'(rdata), 32'(exp));
    if (!was_stall) check("latency", 32'(l), 32'd1);
    rdv = rdata;
    latv = l;
    $display("txn %s off=%0d wdata=%h rdata=%h lat=%0d", w ? "st" : "ld", off, d, rdata, l);
    req = 1'b0;
    tick();
    check("ready_pulse", 32'(ready), 32'd0);
  endtask

  initial begin
    // 1: reset and idle status
    do_reset(3);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    tick();
    bus(0, 2'd1, 16'h0, 0, rd, lat);
    check("status_reset", 32'(rd), 32'h4000);

    // 2: scratch round trip, DATA load, address decode
    bus(1, 2'd3, 16'h1234, 0, rd, lat);
    bus(0, 2'd3, 16'h0, 0, rd, lat);
    check("scratch", 32'(rd), 32'h1234);
    bus(0, 2'd0, 16'h0, 0, rd, lat);
    check("data_load", 32'(rd), 32'h0);
    addr = 16'hFF02; #1;
    check("hit_in", 32'(hit), 32'd1);
    addr = 16'hFEFF; #1;
    check("hit_out", 32'(hit), 32'd0);
    req = 1'b1; wr = 1'b1; addr = 16'h1230; wdata = 16'hDEAD;
    repeat (3) begin
      tick();
      check("miss_ready", 32'(ready), 32'd0);
    end
    req = 1'b0;
    bus(0, 2'd1, 16'h0, 0, rd, lat);
    check("miss_no_push", 32'(rd), 32'h4000);

    // 3: fill, stall, release, drain order
    out_ready = 1'b0;
    popped.delete();
    for (int i = 1; i <= DEPTH; i++) bus(1, 2'd0, 16'(i), 0, rd, lat);
    bus(0, 2'd1, 16'h0, 0, rd, lat);
    check("status_full", 32'(rd), 32'h8008);
    bus(1, 2'd0, 16'd9, 1, rd, lat);
    check("stall_latency", 32'(lat), 32'd4);
    check("first_pop", (popped.size() > 0) ? 32'(popped[0]) : 32'hFFFF_FFFF, 32'd1);
    out_ready = 1'b0;
    bus(0, 2'd1, 16'h0, 0, rd, lat);
    check("status_refill", 32'(rd), 32'h8008);
    out_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    out_ready = 1'b0;
    check("drain_count", 32'(popped.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      check("drain_order", (i < popped.size()) ? 32'(popped[i]) : 32'hFFFF_FFFF, 32'(i + 1));

    // 4: flush coincident with pop
    for (int i = 0; i < 3; i++) bus(1, 2'd0, 16'($urandom), 0, rd, lat);
    out_ready = 1'b1;
    bus(1, 2'd1, 16'h0001, 0, rd, lat);
    check("flush_valid", 32'(out_valid), 32'd0);
    bus(0, 2'd1, 16'h0, 0, rd, lat);
    check("flush_status", 32'(rd), 32'h4000);
    out_ready = 1'b0;

    // 5: cycle counter
    bus(1, 2'd2, 16'h0, 0, rd, lat);
    repeat (10) tick();
    bus(0, 2'd2, 16'h0, 0, rd, lat);
`ifdef FRANKIE_MMIO_CYCLE_CNT_EN
    check("cycle_dist", 32'(rd), 32'h000B);
    bus(1, 2'd2, 16'h0, 0, rd, lat);
    repeat (65535) tick();
    bus(0, 2'd2, 16'h0, 0, rd, lat);
    check("cycle_wrap", 32'(rd), 32'h0000);
`else
    check("cycle_off", 32'(rd), 32'h0);
`endif

    // random traffic against the model
    for (int n = 0; n < 60; n++) begin
      out_ready = 1'($urandom_range(0, 1));
      bus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), 1, rd, lat);
      repeat ($urandom_range(0, 2)) tick();
    end

    // 6: reset while a store is stalled
    out_ready = 1'b0;
    bus(1, 2'd1, 16'h0001, 0, rd, lat);
    for (int i = 0; i < DEPTH; i++) bus(1, 2'd0, 16'(16'h0100 + i), 0, rd, lat);
    req = 1'b1; wr = 1'b1; addr = 16'hFF00; wdata = 16'hBEEF;
    repeat (2) begin
      tick();
      check("stall_hold", 32'(ready), 32'd0);
    end
    do_reset(1);
    check("rst_stall_ready", 32'(ready), 32'd0);
    check("rst_stall_valid", 32'(out_valid), 32'd0);
    check("rst_stall_data", 32'(out_data), 32'd0);
    popped.delete();
    out_ready = 1'b1;
    repeat (5) tick();
    check("no_beef", 32'(popped.size()), 32'd0);
    bus(0, 2'd1, 16'h0, 0, rd, lat);
    check("rst_stall_status", 32'(rd), 32'h4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
